ext_link_port: RTL and testbench

- Parametrised bidirectional serial port carrying one bus word between two bus systems over the external GPIO link: ext_data_out/ext_data_in plus an ack_out/ack_in return line.
- Next generation of the fixed 8-bit external transmitter/receiver: width-generic, optional parity, ACK timeout with bounded retransmit, sequence bit for duplicate rejection, and synchronised link inputs.
- Sits between a bus slave's write-data register (TX side) and its receive register (RX side).

---
 rtl/ext_link_port.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_ext_link_port.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_link_port.sv
// ext_link_port: one-word bidirectional serial port over an external GPIO link.
// TX frames a latched word as start, seq, data (LSB first), optional even parity
// and stop, then waits for an ACK and retransmits a bounded number of times.
// RX samples mid-bit, rejects bad frames, suppresses duplicates by seq bit and
// answers good frames with a 2-bit-period ACK pulse.
module ext_link_port #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1,
    parameter int ACK_TIMEOUT  = 4,
    parameter int MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_fail,
    output logic [2:0]        state_tx,
    output logic              tick,
    output logic              ext_data_out,
    input  logic              ack_in,
    input  logic              ext_data_in,
    output logic              ack_out,
    input  logic              receiver_en,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int RW = $clog2(2 * CLKS_PER_BIT);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [RW-1:0] HALF_LAST = RW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [RW-1:0] BIT_LAST  = RW'(CLKS_PER_BIT - 1);
    localparam logic [RW-1:0] ACK_LAST  = RW'(2 * CLKS_PER_BIT - 1);
    localparam logic [5:0]    DW6       = 6'(DATA_W);
    localparam logic [5:0]    RX_LAST   = 6'(DATA_W + 1 + PARITY_EN);
    localparam logic [15:0]   WIN_LAST  = 16'(ACK_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        TX_IDLE     = 3'd0,
        TX_START    = 3'd1,
        TX_DATA     = 3'd2,
        TX_PARITY   = 3'd3,
        TX_STOP     = 3'd4,
        TX_WAIT_ACK = 3'd5,
        TX_DONE     = 3'd6,
        TX_FAIL     = 3'd7
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START_CHK,
        RX_BITS,
        RX_ACK
    } rx_state_t;

    // Even-parity bit: makes the count of ones over {seq, data, parity} even.
    function automatic logic even_par(input logic s, input logic [DATA_W-1:0] d);
        return s ^ (^d);
    endfunction

    logic [TW-1:0]     tick_cnt;
    logic              ext_sync_p0, ext_sync_p1, ext_sync_p2;
    logic              ack_sync_p0, ack_sync_p1;

    tx_state_t         tx_state;
    logic              tx_pend, tx_seq, ext_out_r, tx_done_r, tx_fail_r;
    logic [DATA_W-1:0] tx_buf, tx_shift;
    logic [5:0]        tx_bit_cnt;
    logic [15:0]       ack_win;
    logic [3:0]        retry_cnt;

    rx_state_t         rx_state;
    logic [RW-1:0]     rx_cnt;
    logic [5:0]        rx_idx;
    logic              rx_seq_r, rx_par_r, rx_last_seq;
    logic              rx_valid_r, rx_err_r, ack_out_r;
    logic [DATA_W-1:0] rx_shift, rx_data_r;
    logic              rx_par_ok;

    assign tick         = (tick_cnt == TICK_LAST);
    assign tx_busy      = (tx_state != TX_IDLE) || tx_pend;
    assign tx_done      = tx_done_r;
    assign tx_fail      = tx_fail_r;
    assign state_tx     = tx_state;
    assign ext_data_out = ext_out_r;
    assign ack_out      = ack_out_r;
    assign rx_data      = rx_data_r;
    assign rx_valid     = rx_valid_r;
    assign rx_err       = rx_err_r;
    assign rx_par_ok    = (PARITY_EN == 0) || (even_par(rx_seq_r, rx_shift) == rx_par_r);

    // Free-running bit-period counter for the transmitter.
    always_ff @(posedge clk) begin
        if (reset || tick_cnt == TICK_LAST) tick_cnt <= '0;
        else                                tick_cnt <= tick_cnt + TW'(1);
    end

    // Two-flop synchronisers for the asynchronous link inputs, plus one delay for edge detect.
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_sync_p0 <= 1'b1;
            ext_sync_p1 <= 1'b1;
            ext_sync_p2 <= 1'b1;
            ack_sync_p0 <= 1'b0;
            ack_sync_p1 <= 1'b0;
        end else begin
            ext_sync_p0 <= ext_data_in;
            ext_sync_p1 <= ext_sync_p0;
            ext_sync_p2 <= ext_sync_p1;
            ack_sync_p0 <= ack_in;
            ack_sync_p1 <= ack_sync_p0;
        end
    end

    // TX FSM: the line value for each state is registered on entry to that state.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state   <= TX_IDLE;
            tx_pend    <= 1'b0;
            tx_seq     <= 1'b0;
            tx_bit_cnt <= '0;
            ack_win    <= '0;
            retry_cnt  <= '0;
            ext_out_r  <= 1'b1;
            tx_done_r  <= 1'b0;
            tx_fail_r  <= 1'b0;
        end else begin
            tx_done_r <= 1'b0;
            tx_fail_r <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pend) begin
                        if (tick) begin
                            tx_pend   <= 1'b0;
                            tx_state  <= TX_START;
                            ext_out_r <= 1'b0;
                        end
                    end else if (tx_start) begin
                        tx_pend   <= 1'b1;
                        tx_buf    <= tx_data;
                        retry_cnt <= '0;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        tx_state   <= TX_DATA;
                        ext_out_r  <= tx_seq;
                        tx_shift   <= tx_buf;
                        tx_bit_cnt <= '0;
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (tx_bit_cnt == DW6) begin
                            if (PARITY_EN != 0) begin
                                tx_state  <= TX_PARITY;
                                ext_out_r <= even_par(tx_seq, tx_buf);
                            end else begin
                                tx_state  <= TX_STOP;
                                ext_out_r <= 1'b1;
                            end
                        end else begin
                            ext_out_r  <= tx_shift[0];
                            tx_shift   <= tx_shift >> 1;
                            tx_bit_cnt <= tx_bit_cnt + 6'd1;
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick) begin
                        tx_state  <= TX_STOP;
                        ext_out_r <= 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        tx_state <= TX_WAIT_ACK;
                        ack_win  <= '0;
                    end
                end
                TX_WAIT_ACK: begin
                    if (ack_sync_p1) begin
                        tx_state  <= TX_DONE;
                        tx_done_r <= 1'b1;
                    end else if (tick) begin
                        if (ack_win == WIN_LAST) begin
                            if (retry_cnt < RETRY_MAX) begin
                                retry_cnt <= retry_cnt + 4'd1;
                                tx_state  <= TX_START;
                                ext_out_r <= 1'b0;
                            end else begin
                                tx_state  <= TX_FAIL;
                                tx_fail_r <= 1'b1;
                            end
                        end else begin
                            ack_win <= ack_win + 16'd1;
                        end
                    end
                end
                TX_DONE: begin
                    tx_seq   <= ~tx_seq;
                    tx_state <= TX_IDLE;
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // RX FSM: mid-bit sampling from the start edge, duplicate filter and ACK pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            rx_last_seq <= 1'b1;
            rx_data_r   <= '0;
            rx_valid_r  <= 1'b0;
            rx_err_r    <= 1'b0;
            ack_out_r   <= 1'b0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_err_r   <= 1'b0;
            if (!receiver_en) begin
                rx_state  <= RX_IDLE;
                ack_out_r <= 1'b0;
            end else begin
                case (rx_state)
                    RX_IDLE: begin
                        if (ext_sync_p2 && !ext_sync_p1) begin
                            rx_state <= RX_START_CHK;
                            rx_cnt   <= '0;
                        end
                    end
                    RX_START_CHK: begin
                        if (rx_cnt == HALF_LAST) begin
                            rx_cnt <= '0;
                            rx_idx <= '0;
                            rx_state <= ext_sync_p1 ? RX_IDLE : RX_BITS;
                        end else begin
                            rx_cnt <= rx_cnt + RW'(1);
                        end
                    end
                    RX_BITS: begin
                        if (rx_cnt == BIT_LAST) begin
                            rx_cnt <= '0;
                            rx_idx <= rx_idx + 6'd1;
                            if (rx_idx == 6'd0) begin
                                rx_seq_r <= ext_sync_p1;
                            end else if (rx_idx == RX_LAST) begin
                                if (ext_sync_p1 && rx_par_ok) begin
                                    if (rx_seq_r != rx_last_seq) begin
                                        rx_data_r   <= rx_shift;
                                        rx_valid_r  <= 1'b1;
                                        rx_last_seq <= rx_seq_r;
                                    end
                                    rx_state  <= RX_ACK;
                                    ack_out_r <= 1'b1;
                                end else begin
                                    rx_err_r <= 1'b1;
                                    rx_state <= RX_IDLE;
                                end
                            end else if (rx_idx <= DW6) begin
                                rx_shift <= DATA_W'({ext_sync_p1, rx_shift} >> 1);
                            end else begin
                                rx_par_r <= ext_sync_p1;
                            end
                        end else begin
                            rx_cnt <= rx_cnt + RW'(1);
                        end
                    end
                    default: begin
                        if (rx_cnt == ACK_LAST) begin
                            ack_out_r <= 1'b0;
                            rx_state  <= RX_IDLE;
                        end else begin
                            rx_cnt <= rx_cnt + RW'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ext_link_port.sv
// tb_ext_link_port: two loopback pairs of ext_link_port (8-bit with parity, and
// 16-bit without parity) driven with random payloads and link faults, checked
// against a transaction-level model of sequence bits, retries and duplicates.
module tb_ext_link_port;

    localparam int CPB   = 4;
    localparam int RETRY = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, reset_c;
    logic ack_block, par_fault, glitch_low;

    // pair A -> B (8-bit, parity)
    logic       a_start;
    logic [7:0] a_data;
    logic       a_busy, a_done, a_fail, a_tick, a_out, a_ack_out, a_rx_valid, a_rx_err;
    logic [2:0] a_state;
    logic [7:0] a_rx_data;
    logic       b_busy, b_done, b_fail, b_tick, b_out, b_ack, b_rx_valid, b_rx_err, b_in;
    logic [2:0] b_state;
    logic [7:0] b_rx_data;

    // pair C -> D (16-bit, no parity, 8 clocks per bit)
    logic        c_start;
    logic [15:0] c_data;
    logic        c_busy, c_done, c_fail, c_tick, c_out, c_ack_out, c_rx_valid, c_rx_err;
    logic [2:0]  c_state;
    logic [15:0] c_rx_data;
    logic        d_busy, d_done, d_fail, d_tick, d_out, d_ack, d_rx_valid, d_rx_err;
    logic [2:0]  d_state;
    logic [15:0] d_rx_data;

    assign b_in = glitch_low ? 1'b0 : (a_out ^ (par_fault && a_state == 3'd3));

    ext_link_port u_a (
        .clk(clk), .reset(reset), .tx_start(a_start), .tx_data(a_data),
        .tx_busy(a_busy), .tx_done(a_done), .tx_fail(a_fail), .state_tx(a_state),
        .tick(a_tick), .ext_data_out(a_out), .ack_in(b_ack & ~ack_block),
        .ext_data_in(b_out), .ack_out(a_ack_out), .receiver_en(1'b1),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_err(a_rx_err)
    );
    ext_link_port u_b (
        .clk(clk), .reset(reset), .tx_start(1'b0), .tx_data(8'h00),
        .tx_busy(b_busy), .tx_done(b_done), .tx_fail(b_fail), .state_tx(b_state),
        .tick(b_tick), .ext_data_out(b_out), .ack_in(a_ack_out),
        .ext_data_in(b_in), .ack_out(b_ack), .receiver_en(1'b1),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_err(b_rx_err)
    );
    ext_link_port #(.DATA_W(16), .CLKS_PER_BIT(8), .PARITY_EN(0)) u_c (
        .clk(clk), .reset(reset_c), .tx_start(c_start), .tx_data(c_data),
        .tx_busy(c_busy), .tx_done(c_done), .tx_fail(c_fail), .state_tx(c_state),
        .tick(c_tick), .ext_data_out(c_out), .ack_in(d_ack),
        .ext_data_in(d_out), .ack_out(c_ack_out), .receiver_en(1'b1),
        .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_err(c_rx_err)
    );
    ext_link_port #(.DATA_W(16), .CLKS_PER_BIT(8), .PARITY_EN(0)) u_d (
        .clk(clk), .reset(reset), .tx_start(1'b0), .tx_data(16'h0000),
        .tx_busy(d_busy), .tx_done(d_done), .tx_fail(d_fail), .state_tx(d_state),
        .tick(d_tick), .ext_data_out(d_out), .ack_in(c_ack_out),
        .ext_data_in(c_out), .ack_out(d_ack), .receiver_en(1'b1),
        .rx_data(d_rx_data), .rx_valid(d_rx_valid), .rx_err(d_rx_err)
    );

    int n_chk = 0, n_bad = 0;
    int n_valid = 0, n_err = 0, n_done = 0, n_fail = 0, n_ack = 0;
    int n_dvalid = 0, n_cdone = 0;
    logic b_ack_prev = 1'b0;
    logic [15:0] d_last = '0;
    logic [7:0]  got_data[$];
    logic        mon_seq[$];
    logic [7:0]  mon_data[$];
    logic        mon_ok[$];

    // transaction-level model state
    logic       m_seq = 1'b0;
    logic       m_last = 1'b1;
    logic [7:0] m_rxdata = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Pulse/event counters, sampled on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (b_rx_valid) begin n_valid++; got_data.push_back(b_rx_data); end
            if (b_rx_err) n_err++;
            if (a_done) n_done++;
            if (a_fail) n_fail++;
            if (b_ack && !b_ack_prev) n_ack++;
            b_ack_prev = b_ack;
            if (d_rx_valid) begin n_dvalid++; d_last = d_rx_data; end
            if (c_done) n_cdone++;
        end
    end

    // Line decoder on A's output: mid-bit sampling of the frame format.
    initial begin
        logic s, p, st;
        logic [7:0] d;
        @(negedge clk);
        while (reset) @(negedge clk);
        forever begin
            @(negedge clk);
            if (a_out == 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                repeat (CPB) @(negedge clk);
                s = a_out;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = a_out;
                end
                repeat (CPB) @(negedge clk);
                p = a_out;
                repeat (CPB) @(negedge clk);
                st = a_out;
                mon_seq.push_back(s);
                mon_data.push_back(d);
                mon_ok.push_back(~(s ^ (^d) ^ p) & st);
            end
        end
    end

    // mode 0: clean link, 1: ACK blocked, 2: parity flipped on the first frame
    task automatic run_txn(input logic [7:0] d, input int mode);
        int v0, e0, dn0, f0, cnt, n_att;
        logic exp_valid;
        v0 = n_valid; e0 = n_err; dn0 = n_done; f0 = n_fail;
        got_data.delete(); mon_seq.delete(); mon_data.delete(); mon_ok.delete();
        n_att = (mode == 1) ? RETRY + 1 : (mode == 2) ? 2 : 1;
        exp_valid = (m_seq != m_last);
        if (exp_valid) begin m_last = m_seq; m_rxdata = d; end
        ack_block = (mode == 1);
        par_fault = (mode == 2);
        a_data = d;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        cnt = 0;
        while (n_done == dn0 && n_fail == f0 && cnt < 3000) begin
            step();
            if (n_err != e0) par_fault = 1'b0;
            cnt++;
        end
        check_eq("txn_timeout", 32'(cnt < 3000), 1);
        ack_block = 1'b0;
        par_fault = 1'b0;
        repeat (6 * CPB) step();
        check_eq("tx_done", n_done - dn0, (mode != 1) ? 1 : 0);
        check_eq("tx_fail", n_fail - f0, (mode == 1) ? 1 : 0);
        check_eq("rx_valid", n_valid - v0, exp_valid ? 1 : 0);
        check_eq("rx_err", n_err - e0, (mode == 2) ? 1 : 0);
        check_eq("frames", mon_seq.size(), n_att);
        for (int i = 0; i < mon_seq.size(); i++) begin
            check_eq("frame_seq", mon_seq[i], m_seq);
            check_eq("frame_data", mon_data[i], d);
            check_eq("frame_fmt", mon_ok[i], 1);
        end
        if (exp_valid && got_data.size() > 0) check_eq("rx_word", got_data[0], d);
        check_eq("rx_data", b_rx_data, m_rxdata);
        check_eq("busy_end", a_busy, 0);
        if (mode != 1) m_seq = ~m_seq;
    endtask

    initial begin
        int cnt, ticks, v0, e0, k0;
        reset = 1'b1; reset_c = 1'b1;
        a_start = 1'b0; a_data = '0; c_start = 1'b0; c_data = '0;
        ack_block = 1'b0; par_fault = 1'b0; glitch_low = 1'b0;
        repeat (5) step();
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_done_fail", {a_done, a_fail}, 0);
        check_eq("rst_state", a_state, 0);
        check_eq("rst_tick", a_tick, 0);
        check_eq("rst_line", {a_out, b_out, c_out}, 3'b111);
        check_eq("rst_ack", {a_ack_out, b_ack}, 0);
        check_eq("rst_rx", {b_rx_data, b_rx_valid, b_rx_err}, 0);
        reset = 1'b0; reset_c = 1'b0;
        step();

        ticks = 0;
        for (int i = 0; i < 4 * CPB; i++) begin
            if (a_tick) ticks++;
            step();
        end
        check_eq("tick_rate", ticks, 4);

        run_txn(8'hA5, 0);
        run_txn(8'h3C, 0);
        for (int i = 0; i < 3; i++) run_txn(8'($urandom), 0);
        run_txn(8'($urandom), 1);
        run_txn(8'($urandom), 0);
        run_txn(8'($urandom), 2);
        for (int i = 0; i < 5; i++) run_txn(8'($urandom), int'($urandom_range(0, 2)));

        // single-cycle low glitch on an idle receiver line
        v0 = n_valid; e0 = n_err; k0 = n_ack;
        glitch_low = 1'b1;
        step();
        glitch_low = 1'b0;
        repeat (6 * CPB) step();
        check_eq("glitch_err", n_err - e0, 0);
        check_eq("glitch_valid", n_valid - v0, 0);
        check_eq("glitch_ack", n_ack - k0, 0);

        // wide, parity-less pair
        v0 = n_dvalid; k0 = n_cdone;
        c_data = 16'hBEEF;
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        cnt = 0;
        while (n_cdone == k0 && cnt < 3000) begin step(); cnt++; end
        check_eq("wide_timeout", 32'(cnt < 3000), 1);
        check_eq("wide_valid", n_dvalid - v0, 1);
        check_eq("wide_data", d_last, 16'hBEEF);
        check_eq("wide_rxdata", d_rx_data, 16'hBEEF);
        repeat (48) step();

        // reset in the middle of the data phase
        c_data = 16'($urandom);
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        cnt = 0;
        while (c_state != 3'd2 && cnt < 500) begin step(); cnt++; end
        check_eq("mid_reach", 32'(cnt < 500), 1);
        repeat (24) step();
        check_eq("mid_in_data", c_state, 2);
        reset_c = 1'b1;
        step();
        check_eq("mid_rst_state", c_state, 0);
        check_eq("mid_rst_line", c_out, 1);
        check_eq("mid_rst_busy", c_busy, 0);
        reset_c = 1'b0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
